// File: rtl/frogger_game_fsm_if.sv
// frogger_game_fsm_if: game sequencer bus; master drives start/tick/collision/frog row, slave returns state/active/respawn/lives/score
interface frogger_game_fsm_if;
  logic       i_Game_Start;
  logic       i_Frame_Tick;
  logic       i_Collided;
  logic [5:0] i_Frogger_Y;
  logic [2:0] o_State;
  logic       o_Game_Active;
  logic       o_Respawn;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  modport master (
    output i_Game_Start, i_Frame_Tick, i_Collided, i_Frogger_Y,
    input  o_State, o_Game_Active, o_Respawn, o_Lives, o_Score
  );
  modport slave (
    input  i_Game_Start, i_Frame_Tick, i_Collided, i_Frogger_Y,
    output o_State, o_Game_Active, o_Respawn, o_Lives, o_Score
  );
endinterface

// File: rtl/frogger_game_fsm.sv
// frogger_game_fsm: Frogger game sequencer; ports i_Clk, i_Reset (sync, high), game bus (start/tick/collided/frog row in; state/active/respawn/lives/score out)
module frogger_game_fsm #(
  parameter int c_START_LIVES   = 3,
  parameter int c_GOAL_ROW      = 0,
  parameter int c_WIN_SCORE     = 5,
  parameter int c_FREEZE_FRAMES = 60,
  parameter int c_END_FRAMES    = 120
) (
  input logic               i_Clk,
  input logic               i_Reset,
  frogger_game_fsm_if.slave game
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEANUP   = 3'd1,
    RUNNING   = 3'd2,
    FREEZE    = 3'd3,
    P1_WINS   = 3'd4,
    GAME_OVER = 3'd5
  } state_t;
  state_t     state_q;
  logic       active_q, respawn_q, coll_prev_q;
  logic [1:0] lives_q, blank_q;
  logic [6:0] score_q, score_inc;
  logic [7:0] timer_q;
  logic       coll_evt, goal;
  always_comb begin
    coll_evt  = game.i_Collided & ~coll_prev_q;
    goal      = game.i_Frogger_Y == 6'(c_GOAL_ROW);
    score_inc = score_q == 7'd99 ? score_q : score_q + 7'd1;
  end
  // blank_q masks the respawn cycle and the one after it while the frog and collision blocks catch up
  always_ff @(posedge i_Clk) begin
    respawn_q <= 1'b0;
    if (i_Reset) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      lives_q     <= 2'(c_START_LIVES);
      score_q     <= 7'd0;
      timer_q     <= 8'd0;
      blank_q     <= 2'd0;
      coll_prev_q <= 1'b0;
    end else begin
      coll_prev_q <= game.i_Collided;
      case (state_q)
        IDLE: if (game.i_Game_Start) state_q <= CLEANUP;
        CLEANUP: begin
          score_q   <= 7'd0;
          lives_q   <= 2'(c_START_LIVES);
          state_q   <= RUNNING;
          active_q  <= 1'b1;
          respawn_q <= 1'b1;
          blank_q   <= 2'd2;
        end
        RUNNING: begin
          if (blank_q != 2'd0) blank_q <= blank_q - 2'd1;
          else if (coll_evt) begin
            timer_q  <= 8'd0;
            active_q <= 1'b0;
            lives_q  <= lives_q > 2'd1 ? lives_q - 2'd1 : 2'd0;
            state_q  <= lives_q > 2'd1 ? FREEZE : GAME_OVER;
          end else if (goal) begin
            timer_q  <= 8'd0;
            active_q <= 1'b0;
            score_q  <= score_inc;
            state_q  <= score_inc == 7'(c_WIN_SCORE) ? P1_WINS : FREEZE;
          end
        end
        FREEZE: if (game.i_Frame_Tick) begin
          if (timer_q == 8'(c_FREEZE_FRAMES - 1)) begin
            state_q   <= RUNNING;
            active_q  <= 1'b1;
            respawn_q <= 1'b1;
            blank_q   <= 2'd2;
          end else timer_q <= timer_q + 8'd1;
        end
        P1_WINS, GAME_OVER: if (game.i_Frame_Tick) begin
          if (timer_q == 8'(c_END_FRAMES - 1)) state_q <= IDLE;
          else timer_q <= timer_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign game.o_State       = state_q;
  assign game.o_Game_Active = active_q;
  assign game.o_Respawn     = respawn_q;
  assign game.o_Lives       = lives_q;
  assign game.o_Score       = score_q;
endmodule

// File: tb/tb_frogger_game_fsm.sv
// tb_frogger_game_fsm: directed table plus hand sequences for the Frogger game sequencer
module tb_frogger_game_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  frogger_game_fsm_if game();
  frogger_game_fsm dut (.i_Clk(clk), .i_Reset(rst), .game(game));
  typedef struct {
    logic       st;
    logic       tk;
    logic       co;
    logic [5:0] y;
    logic [2:0] e_st;
    logic       e_act;
    logic       e_rsp;
    logic [1:0] e_lv;
    logic [6:0] e_sc;
  } vec_t;
  int checks = 0;
  int errors = 0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic t, input logic c, input logic [5:0] y);
    game.i_Game_Start = s;
    game.i_Frame_Tick = t;
    game.i_Collided   = c;
    game.i_Frogger_Y  = y;
  endtask
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic check_all(input string nm, input int st, input int act, input int rsp, input int lv, input int sc);
    chk({nm, ".state"}, int'(game.o_State), st);
    chk({nm, ".active"}, int'(game.o_Game_Active), act);
    chk({nm, ".respawn"}, int'(game.o_Respawn), rsp);
    chk({nm, ".lives"}, int'(game.o_Lives), lv);
    chk({nm, ".score"}, int'(game.o_Score), sc);
  endtask
  task automatic run_ticks(input int n, input int st);
    for (int i = 0; i < n; i++) begin
      game.i_Frame_Tick = 1'b0;
      step();
      game.i_Frame_Tick = 1'b1;
      step();
      game.i_Frame_Tick = 1'b0;
      if (i < n - 1) chk("tick_hold", int'(game.o_State), st);
    end
  endtask
  task automatic settle();
    step();
    chk("respawn_one_cycle", int'(game.o_Respawn), 0);
    chk("active_after_respawn", int'(game.o_Game_Active), 1);
    step();
  endtask
  initial begin
    vec_t tv[6];
    tv[0] = '{1'b1, 1'b0, 1'b0, 6'd12, 3'd1, 1'b0, 1'b0, 2'd3, 7'd0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 6'd12, 3'd2, 1'b1, 1'b1, 2'd3, 7'd0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 6'd0,  3'd2, 1'b1, 1'b0, 2'd3, 7'd0};
    tv[3] = '{1'b0, 1'b1, 1'b0, 6'd0,  3'd2, 1'b1, 1'b0, 2'd3, 7'd0};
    tv[4] = '{1'b0, 1'b0, 1'b0, 6'd0,  3'd3, 1'b0, 1'b0, 2'd3, 7'd1};
    tv[5] = '{1'b0, 1'b1, 1'b0, 6'd12, 3'd3, 1'b0, 1'b0, 2'd3, 7'd1};
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    step();
    check_all("reset", 0, 0, 0, 3, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(tv[i].st, tv[i].tk, tv[i].co, tv[i].y);
      step();
      check_all($sformatf("vec%0d", i), tv[i].e_st, tv[i].e_act, tv[i].e_rsp, tv[i].e_lv, tv[i].e_sc);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    run_ticks(59, 3);
    check_all("freeze_exit", 2, 1, 1, 3, 1);
    settle();
    drive(1'b0, 1'b0, 1'b1, 6'd12);
    step();
    check_all("coll_hit", 3, 0, 0, 2, 1);
    run_ticks(60, 3);
    check_all("coll_held_exit", 2, 1, 1, 2, 1);
    settle();
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("coll_held_no_repeat", 2, 1, 0, 2, 1);
    end
    game.i_Collided = 1'b0;
    step();
    drive(1'b0, 1'b0, 1'b1, 6'd0);
    step();
    check_all("coll_and_goal", 3, 0, 0, 1, 1);
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    run_ticks(60, 3);
    chk("coll_goal_exit", int'(game.o_State), 2);
    settle();
    drive(1'b0, 1'b0, 1'b1, 6'd12);
    step();
    check_all("game_over", 5, 0, 0, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 6'd12);
    step();
    chk("start_ignored_over", int'(game.o_State), 5);
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    run_ticks(120, 5);
    check_all("over_to_idle", 0, 0, 0, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 6'd12);
    step();
    check_all("restart", 1, 0, 0, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    step();
    check_all("restart_run", 2, 1, 1, 3, 0);
    settle();
    for (int k = 1; k <= 5; k++) begin
      game.i_Frogger_Y = 6'd0;
      step();
      chk($sformatf("cross%0d.score", k), int'(game.o_Score), k);
      chk($sformatf("cross%0d.state", k), int'(game.o_State), k == 5 ? 4 : 3);
      game.i_Frogger_Y = 6'd12;
      if (k < 5) begin
        run_ticks(60, 3);
        chk($sformatf("cross%0d.exit", k), int'(game.o_State), 2);
        settle();
      end
    end
    drive(1'b1, 1'b0, 1'b0, 6'd12);
    step();
    chk("start_ignored_win", int'(game.o_State), 4);
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    run_ticks(120, 4);
    check_all("win_to_idle", 0, 0, 0, 3, 5);
    drive(1'b1, 1'b0, 1'b0, 6'd12);
    step();
    drive(1'b0, 1'b0, 1'b0, 6'd12);
    step();
    settle();
    drive(1'b0, 1'b0, 1'b1, 6'd12);
    step();
    check_all("pre_reset_hit", 3, 0, 0, 2, 0);
    game.i_Collided = 1'b0;
    run_ticks(10, 3);
    rst = 1'b1;
    step();
    check_all("mid_freeze_reset", 0, 0, 0, 3, 0);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
